axis_pkt_rr_arbiter: RTL and testbench
======================================

# axis_pkt_rr_arbiter

Packet-granular round-robin arbiter that shares one AXI-Stream egress between NUM_MASTERS ingress streams in the NMU datapath. Each ingress carries routing in tuser, as consumed by the tuser/tdest swap stage. The arbiter locks a grant for a whole packet (until tlast) and tags each beat's tid with the winning source index. A 2-entry register slice on the egress breaks the timing path toward the downstream swap/switch stage.

## Interface
- AXIS_BUS_WIDTH, 64, tdata width in bits; tkeep is AXIS_BUS_WIDTH/8.
- AXIS_DEST_WIDTH, 4, tuser width; passed through unchanged.
- NUM_MASTERS, 4, number of ingress streams, 2..16.
- AXIS_ID_WIDTH, 4, output tid width; must be ≥ clog2(NUM_MASTERS); upper bits are zero.

Ports:
- aclk  in  1  clock; all logic is on the rising edge.
- areset  in  1  synchronous, active-high reset.
- axis_in_tdata  in  NUM_MASTERS*AXIS_BUS_WIDTH  flattened; master i occupies slice i.
- axis_in_tuser  in  NUM_MASTERS*AXIS_DEST_WIDTH  per-master routing.
- axis_in_tkeep  in  NUM_MASTERS*AXIS_BUS_WIDTH/8  per-master byte enables.
- axis_in_tlast / axis_in_tvalid  in  NUM_MASTERS  per-master flags.
- axis_in_tready  out  NUM_MASTERS  per-master ready.
- axis_out_tdata/tuser/tkeep/tlast  out  widths as one master  data of the granted master.
- axis_out_tid  out  AXIS_ID_WIDTH  index of the source master.
- axis_out_tvalid  out  1; axis_out_tready  in  1.

## Operation
- FSM states are IDLE and LOCK. Registers are grant (clog2 width) and last_grant.
- IDLE:
  - Scan axis_in_tvalid starting at last_grant+1, wrapping mod NUM_MASTERS; the first asserted index wins.
  - On a win: grant ← index, go to LOCK. With no request, stay in IDLE.
  - axis_in_tready is all zero in IDLE.
- LOCK:
  - axis_in_tready[grant] = (slice occupancy < 2); every other ready bit is 0.
  - A beat is accepted when axis_in_tvalid[grant] & axis_in_tready[grant]. The beat {tdata, tuser, tkeep, tlast, tid=grant} is written into the slice.
  - An accepted beat with tlast=1 sets last_grant ← grant and returns the FSM to IDLE.
  - tvalid from non-granted masters is ignored. They hold their data, per AXI-Stream rules.
- Fairness: with all masters requesting continuously, grants rotate 0,1,2,…,N-1,0.
- Register slice: a 2-entry FIFO.
  - axis_out_* is driven from the head entry.
  - The head pops on axis_out_tvalid & axis_out_tready.
  - Push and pop in the same cycle leave occupancy unchanged.
- Beats leave the slice in acceptance order. Packets from different masters are never interleaved.
- A granted master holding tvalid low mid-packet keeps the grant indefinitely. There is no timeout.

## Timing
- Reset values:
  - FSM = IDLE; grant = 0.
  - last_grant = NUM_MASTERS-1, so master 0 has first priority.
  - Slice empty: axis_out_tvalid = 0; axis_in_tready = 0.
  - Data outputs are don't-care but must not be X-propagating; registering them to 0 is acceptable.
- Arbitration latency: a request seen in IDLE in cycle t gives LOCK with tready in cycle t+1, provided the slice has space.
- Datapath latency: a beat accepted in cycle t appears on axis_out in cycle t+1.
- Throughput: 1 beat/cycle within a packet while axis_out_tready=1. There is one bubble cycle (IDLE) between packets. Back-to-back single-beat packets therefore run at 1 beat per 2 cycles.
- Backpressure: with axis_out_tready=0, the slice fills after 2 accepted beats; tready drops in the cycle after the second push. No beat is dropped or duplicated.
- Simultaneous events:
  - A tlast accept and a new request from another master in the same cycle: the new request is evaluated in the following IDLE cycle.
  - A slice pop and push in the same cycle: both occur.
- Reset mid-packet: the FSM and slice clear in the cycle after areset is sampled high. Any partial packet is discarded. The bench must reset upstream sources as well.

## Test plan
- Single master: M2 sends 3 beats (tuser=5) → output shows 3 beats with tid=2, tuser=5, tlast on beat 3; first beat appears 2 cycles after tvalid rises.
- Full contention: M0–M3 each send one 2-beat packet → output order M0,M1,M2,M3; packets are contiguous with a 1-cycle gap between them.
- Rotation after a win: M1 finishes, then M0 and M1 request together → M0 wins (scan starts at 2 and wraps to 0); M1 is served next.
- Backpressure: a 4-beat packet with axis_out_tready=0 for 5 cycles → exactly 2 beats accepted and in_tready low; after release, all 4 beats arrive in order with no loss.
- Single-beat storm: M3 sends 4 one-beat packets, others idle → 4 outputs, tid=3, spaced 2 cycles apart.
- Reset mid-packet: assert areset after beat 2 of 4 → next cycle out_tvalid=0 and all in_tready=0; after reset, M0 has priority.

Source files
------------

// File: rtl/axis_pkt_rr_arbiter.sv
// ---------------------------------------------------------------------------
// axis_pkt_rr_arbiter
//
// Packet-granular round-robin arbiter. It merges NUM_MASTERS AXI-Stream
// ingress ports onto one egress port.
//
// Behaviour:
//   - A grant is held for a whole packet, up to and including the tlast beat.
//   - Every egress beat carries the index of its source master in tid.
//   - The egress is fed from a 2-entry register slice, so no combinational
//     path runs from axis_out_tready back to the ingress side.
//
// Ports:
//   aclk, areset       clock; synchronous active-high reset
//   axis_in_tdata      NUM_MASTERS x AXIS_BUS_WIDTH, master i in slice i
//   axis_in_tuser      NUM_MASTERS x AXIS_DEST_WIDTH routing, passed through
//   axis_in_tkeep      NUM_MASTERS x AXIS_BUS_WIDTH/8 byte enables
//   axis_in_tlast      per-master end-of-packet flag
//   axis_in_tvalid     per-master valid
//   axis_in_tready     per-master ready (only the granted master, in LOCK)
//   axis_out_*         head beat of the register slice
//   axis_out_tid       source master index, zero-extended to AXIS_ID_WIDTH
// ---------------------------------------------------------------------------
module axis_pkt_rr_arbiter #(
   parameter int AXIS_BUS_WIDTH  = 64,
   parameter int AXIS_DEST_WIDTH = 4,
   parameter int NUM_MASTERS     = 4,
   parameter int AXIS_ID_WIDTH   = 4
) (
   input  logic                                    aclk,
   input  logic                                    areset,
   input  logic [NUM_MASTERS*AXIS_BUS_WIDTH-1:0]   axis_in_tdata,
   input  logic [NUM_MASTERS*AXIS_DEST_WIDTH-1:0]  axis_in_tuser,
   input  logic [NUM_MASTERS*AXIS_BUS_WIDTH/8-1:0] axis_in_tkeep,
   input  logic [NUM_MASTERS-1:0]                  axis_in_tlast,
   input  logic [NUM_MASTERS-1:0]                  axis_in_tvalid,
   output logic [NUM_MASTERS-1:0]                  axis_in_tready,
   output logic [AXIS_BUS_WIDTH-1:0]               axis_out_tdata,
   output logic [AXIS_DEST_WIDTH-1:0]              axis_out_tuser,
   output logic [AXIS_BUS_WIDTH/8-1:0]             axis_out_tkeep,
   output logic                                    axis_out_tlast,
   output logic [AXIS_ID_WIDTH-1:0]                axis_out_tid,
   output logic                                    axis_out_tvalid,
   input  logic                                    axis_out_tready
);

   localparam int KEEP_W  = AXIS_BUS_WIDTH / 8;
   localparam int GRANT_W = $clog2(NUM_MASTERS);
   localparam int BEAT_W  = AXIS_ID_WIDTH + 1 + KEEP_W + AXIS_DEST_WIDTH + AXIS_BUS_WIDTH;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_LOCK = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [GRANT_W-1:0]   r_grant;
   logic [GRANT_W-1:0]   w_grant_nxt;
   logic [GRANT_W-1:0]   r_last_grant;
   logic [GRANT_W-1:0]   w_last_grant_nxt;

   logic [BEAT_W-1:0]    r_slice [2];
   logic                 r_rd_ptr;
   logic                 r_wr_ptr;
   logic [1:0]           r_count;

   logic                 w_req_found;
   logic [GRANT_W-1:0]   w_req_idx;
   logic [GRANT_W-1:0]   w_scan_idx;
   logic                 w_space;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_sel_last;
   logic [BEAT_W-1:0]    w_beat;

   assign w_space    = (r_count < 2'd2);
   assign w_push     = (r_state == ST_LOCK) & w_space & axis_in_tvalid[r_grant];
   assign w_pop      = axis_out_tvalid & axis_out_tready;
   assign w_sel_last = axis_in_tlast[r_grant];

   // Beat captured from the granted master; tid is the zero-extended grant index.
   assign w_beat = {AXIS_ID_WIDTH'(r_grant),
                    w_sel_last,
                    axis_in_tkeep[int'(r_grant)*KEEP_W +: KEEP_W],
                    axis_in_tuser[int'(r_grant)*AXIS_DEST_WIDTH +: AXIS_DEST_WIDTH],
                    axis_in_tdata[int'(r_grant)*AXIS_BUS_WIDTH +: AXIS_BUS_WIDTH]};

   assign {axis_out_tid, axis_out_tlast, axis_out_tkeep, axis_out_tuser, axis_out_tdata} =
          r_slice[r_rd_ptr];
   assign axis_out_tvalid = (r_count != 2'd0);

   // Round-robin scan from last_grant+1. The loop walks the offsets from
   // farthest to nearest, so the nearest requester is the last one written.
   always_comb begin
      w_req_found = |axis_in_tvalid;
      w_req_idx   = '0;
      w_scan_idx  = '0;
      for (int k = NUM_MASTERS; k >= 1; k--) begin
         w_scan_idx = GRANT_W'((int'(r_last_grant) + k) % NUM_MASTERS);
         w_req_idx  = axis_in_tvalid[w_scan_idx] ? w_scan_idx : w_req_idx;
      end
   end

   // Next-state logic: pick a winner in IDLE, release the lock on an accepted tlast.
   always_comb begin
      w_state_nxt      = r_state;
      w_grant_nxt      = r_grant;
      w_last_grant_nxt = r_last_grant;
      case (r_state)
         ST_IDLE: begin
            if (w_req_found) begin
               w_state_nxt = ST_LOCK;
               w_grant_nxt = w_req_idx;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_LOCK: begin
            if (w_push && w_sel_last) begin
               w_state_nxt      = ST_IDLE;
               w_last_grant_nxt = r_grant;
            end else begin
               w_state_nxt = ST_LOCK;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Only the granted master sees ready, and only while the slice has room.
   always_comb begin
      axis_in_tready          = '0;
      axis_in_tready[r_grant] = (r_state == ST_LOCK) & w_space;
   end

   // Arbiter state registers. Last_grant resets to N-1 so master 0 scans first.
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_state      <= ST_IDLE;
         r_grant      <= '0;
         r_last_grant <= GRANT_W'(NUM_MASTERS - 1);
      end else begin
         r_state      <= w_state_nxt;
         r_grant      <= w_grant_nxt;
         r_last_grant <= w_last_grant_nxt;
      end
   end

   // Two-entry egress slice. Storage is cleared on reset so the outputs never carry X.
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_slice[0] <= '0;
         r_slice[1] <= '0;
         r_rd_ptr   <= 1'b0;
         r_wr_ptr   <= 1'b0;
         r_count    <= 2'd0;
      end else begin
         if (w_push) begin
            r_slice[r_wr_ptr] <= w_beat;
            r_wr_ptr          <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axis_pkt_rr_arbiter
//
// Directed bench for axis_pkt_rr_arbiter.
//
// Stimulus:
//   - Each master has a small beat queue that is driven at posedge+1.
//   - A queue entry advances only when the handshake was observed before
//     that edge.
//
// Checking:
//   - Egress beats are logged at negedge, together with the cycle number
//     in which they appeared.
//   - Each expectation below is hand-timed from the cycle in which the
//     stimulus was loaded.
// ---------------------------------------------------------------------------
module tb_axis_pkt_rr_arbiter;

   localparam int BW = 64;
   localparam int DW = 4;
   localparam int NM = 4;
   localparam int IW = 4;
   localparam int KW = BW / 8;

   logic              aclk = 1'b0;
   logic              areset;
   logic [NM*BW-1:0]  in_tdata;
   logic [NM*DW-1:0]  in_tuser;
   logic [NM*KW-1:0]  in_tkeep;
   logic [NM-1:0]     in_tlast;
   logic [NM-1:0]     in_tvalid;
   logic [NM-1:0]     in_tready;
   logic [BW-1:0]     out_tdata;
   logic [DW-1:0]     out_tuser;
   logic [KW-1:0]     out_tkeep;
   logic              out_tlast;
   logic [IW-1:0]     out_tid;
   logic              out_tvalid;
   logic              out_tready;

   always #5 aclk = ~aclk;

   axis_pkt_rr_arbiter #(
      .AXIS_BUS_WIDTH (BW),
      .AXIS_DEST_WIDTH(DW),
      .NUM_MASTERS    (NM),
      .AXIS_ID_WIDTH  (IW)
   ) dut (
      .aclk           (aclk),
      .areset         (areset),
      .axis_in_tdata  (in_tdata),
      .axis_in_tuser  (in_tuser),
      .axis_in_tkeep  (in_tkeep),
      .axis_in_tlast  (in_tlast),
      .axis_in_tvalid (in_tvalid),
      .axis_in_tready (in_tready),
      .axis_out_tdata (out_tdata),
      .axis_out_tuser (out_tuser),
      .axis_out_tkeep (out_tkeep),
      .axis_out_tlast (out_tlast),
      .axis_out_tid   (out_tid),
      .axis_out_tvalid(out_tvalid),
      .axis_out_tready(out_tready)
   );

   // Per-master source queues
   logic [BW-1:0] src_data [NM][8];
   logic [KW-1:0] src_keep [NM][8];
   logic          src_last [NM][8];
   logic [DW-1:0] src_user [NM];
   int            src_n    [NM];
   int            src_p    [NM];

   // Egress log
   logic [BW-1:0] log_data [32];
   logic [IW-1:0] log_tid  [32];
   logic          log_last [32];
   logic [DW-1:0] log_user [32];
   logic [KW-1:0] log_keep [32];
   int            log_cyc  [32];
   int            log_n;

   int cyc;
   int tot_cnt;
   int pass_cnt;
   int fail_cnt;
   int c0;
   int c1;
   int c2;

   function automatic logic [BW-1:0] mk_data(input int m, input int k);
      logic [BW-1:0] d;
      d = 64'hA5A5_0000_0000_0000 | (64'(m) << 8) | 64'(k);
      return d;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tot_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      for (int m = 0; m < NM; m++) begin
         if (src_p[m] < src_n[m]) begin
            in_tvalid[m]           = 1'b1;
            in_tdata[m*BW +: BW]   = src_data[m][src_p[m]];
            in_tkeep[m*KW +: KW]   = src_keep[m][src_p[m]];
            in_tlast[m]            = src_last[m][src_p[m]];
            in_tuser[m*DW +: DW]   = src_user[m];
         end else begin
            in_tvalid[m]           = 1'b0;
            in_tdata[m*BW +: BW]   = '0;
            in_tkeep[m*KW +: KW]   = '0;
            in_tlast[m]            = 1'b0;
            in_tuser[m*DW +: DW]   = '0;
         end
      end
   endtask

   task automatic tick();
      logic [NM-1:0] hs;
      @(negedge aclk);
      hs = in_tvalid & in_tready;
      if (out_tvalid === 1'b1 && out_tready === 1'b1) begin
         if (log_n < 32) begin
            log_data[log_n] = out_tdata;
            log_tid[log_n]  = out_tid;
            log_last[log_n] = out_tlast;
            log_user[log_n] = out_tuser;
            log_keep[log_n] = out_tkeep;
            log_cyc[log_n]  = cyc;
         end
         log_n++;
      end
      @(posedge aclk);
      cyc++;
      #1;
      for (int m = 0; m < NM; m++) begin
         if (hs[m] === 1'b1) src_p[m]++;
      end
      drive();
   endtask

   task automatic load(input int m, input int n, input logic [DW-1:0] user, input bit all_last);
      for (int k = 0; k < n; k++) begin
         src_data[m][k] = mk_data(m, k);
         src_keep[m][k] = (k == n - 1) ? 8'h0F : 8'hFF;
         src_last[m][k] = all_last || (k == n - 1);
      end
      src_user[m] = user;
      src_n[m]    = n;
      src_p[m]    = 0;
   endtask

   task automatic clear_src();
      for (int m = 0; m < NM; m++) begin
         src_n[m] = 0;
         src_p[m] = 0;
      end
      drive();
   endtask

   task automatic clear_log();
      for (int i = 0; i < 32; i++) begin
         log_data[i] = 'x;
         log_tid[i]  = 'x;
         log_last[i] = 1'bx;
         log_user[i] = 'x;
         log_keep[i] = 'x;
         log_cyc[i]  = -1;
      end
      log_n = 0;
   endtask

   task automatic do_reset();
      areset = 1'b1;
      clear_src();
      tick();
      tick();
      areset = 1'b0;
   endtask

   task automatic check_beat(input int i, input int m, input int k, input logic last,
                             input logic [DW-1:0] user, input int at);
      check($sformatf("b%0d_data", i), 64'(log_data[i]), mk_data(m, k));
      check($sformatf("b%0d_tid", i),  64'(log_tid[i]),  64'(m));
      check($sformatf("b%0d_last", i), 64'(log_last[i]), 64'(last));
      check($sformatf("b%0d_user", i), 64'(log_user[i]), 64'(user));
      check($sformatf("b%0d_cyc", i),  64'(log_cyc[i]),  64'(at));
   endtask

   initial begin
      tot_cnt    = 0;
      pass_cnt   = 0;
      fail_cnt   = 0;
      cyc        = 0;
      out_tready = 1'b1;
      in_tdata   = '0;
      in_tuser   = '0;
      in_tkeep   = '0;
      in_tlast   = '0;
      in_tvalid  = '0;
      clear_log();

      // Reset state
      areset = 1'b1;
      clear_src();
      tick();
      tick();
      check("rst_out_tvalid", 64'(out_tvalid), 64'd0);
      check("rst_in_tready",  64'(in_tready),  64'd0);
      check("rst_out_tdata",  64'(out_tdata),  64'd0);
      areset = 1'b0;

      // Single master: M2, 3 beats, tuser=5
      clear_log();
      c0 = cyc;
      load(2, 3, 4'd5, 1'b0);
      drive();
      repeat (6) tick();
      check("t1_count", 64'(log_n), 64'd3);
      for (int k = 0; k < 3; k++) check_beat(k, 2, k, (k == 2), 4'd5, c0 + 2 + k);
      check("t1_keep_last", 64'(log_keep[2]), 64'h0F);

      // Full contention: M0..M3 each send a 2-beat packet
      do_reset();
      clear_log();
      c0 = cyc;
      for (int m = 0; m < NM; m++) load(m, 2, 4'(m + 8), 1'b0);
      drive();
      repeat (3) tick();
      check("t2_idle_gap_ready", 64'(in_tready), 64'd0);
      repeat (12) tick();
      check("t2_count", 64'(log_n), 64'd8);
      for (int p = 0; p < NM; p++) begin
         for (int k = 0; k < 2; k++) begin
            check_beat(2*p + k, p, k, (k == 1), 4'(p + 8), c0 + 2 + 3*p + k);
         end
      end

      // Rotation after a win: M1 finishes, then M0 and M1 request together
      do_reset();
      clear_log();
      c0 = cyc;
      load(1, 1, 4'd3, 1'b0);
      drive();
      repeat (4) tick();
      c1 = cyc;
      load(0, 1, 4'd1, 1'b0);
      load(1, 1, 4'd2, 1'b0);
      drive();
      repeat (7) tick();
      check("t3_count", 64'(log_n), 64'd3);
      check_beat(0, 1, 0, 1'b1, 4'd3, c0 + 2);
      check_beat(1, 0, 0, 1'b1, 4'd1, c1 + 2);
      check_beat(2, 1, 0, 1'b1, 4'd2, c1 + 4);

      // Backpressure: a 4-beat packet with the egress stalled for 5 cycles
      do_reset();
      clear_log();
      out_tready = 1'b0;
      c0 = cyc;
      load(0, 4, 4'd7, 1'b0);
      drive();
      repeat (5) tick();
      check("t4_accepted",   64'(src_p[0]),   64'd2);
      check("t4_in_tready",  64'(in_tready),  64'd0);
      check("t4_out_tvalid", 64'(out_tvalid), 64'd1);
      check("t4_log_empty",  64'(log_n),      64'd0);
      out_tready = 1'b1;
      repeat (6) tick();
      check("t4_count", 64'(log_n), 64'd4);
      for (int k = 0; k < 4; k++) check_beat(k, 0, k, (k == 3), 4'd7, c0 + 5 + k);

      // Single-beat storm from M3
      do_reset();
      clear_log();
      c0 = cyc;
      load(3, 4, 4'd2, 1'b1);
      drive();
      repeat (12) tick();
      check("t5_count", 64'(log_n), 64'd4);
      for (int k = 0; k < 4; k++) check_beat(k, 3, k, 1'b1, 4'd2, c0 + 2 + 2*k);

      // Reset mid-packet. M0 finishes first, so without a reset M1 would be next.
      clear_log();
      load(0, 1, 4'd0, 1'b0);
      drive();
      repeat (4) tick();
      c0 = cyc;
      load(1, 4, 4'd9, 1'b0);
      drive();
      repeat (3) tick();
      areset = 1'b1;
      clear_src();
      tick();
      check("t6_rst_out_tvalid", 64'(out_tvalid), 64'd0);
      check("t6_rst_in_tready",  64'(in_tready),  64'd0);
      check("t6_pre_count",      64'(log_n),      64'd3);
      check_beat(1, 1, 0, 1'b0, 4'd9, c0 + 2);
      check_beat(2, 1, 1, 1'b0, 4'd9, c0 + 3);
      areset = 1'b0;
      clear_log();
      c2 = cyc;
      load(0, 1, 4'd4, 1'b0);
      load(1, 1, 4'd6, 1'b0);
      drive();
      repeat (7) tick();
      check("t6_post_count", 64'(log_n), 64'd2);
      check_beat(0, 0, 0, 1'b1, 4'd4, c2 + 2);
      check_beat(1, 1, 0, 1'b1, 4'd6, c2 + 4);

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
